tick_timer_fsm: RTL and testbench
=================================

Name: tick_timer_fsm

Overview:
Programmable one-shot/periodic timer that consumes the 1-cycle wrap pulse ("done") produced by the N-bit down-counter prescaler and uses it as its time base (tick_in). It counts a software-loaded number of ticks, then emits an expiry pulse and optionally reloads. It sits directly downstream of the prescaler and drives LEDs/interrupt logic in the workshop designs.

Parameters:
W, 8, width of period/remaining count
CW, 8, width of saturating expiry counter

Ports:
clk  input  1  system clock, all logic on rising edge
rstn  input  1  synchronous active-low reset
tick_in  input  1  time-base pulse from prescaler (1 cycle wide, any spacing incl. every cycle)
start  input  1  level-sampled; load period and begin counting
stop  input  1  abort counting, return to idle
hold  input  1  freeze counting while high (RUN only)
periodic  input  1  mode sampled with start: 1=auto-reload, 0=one-shot
load_val  input  W  period in ticks, sampled with start
busy  output  1  high in RUN or PAUSE
expired  output  1  1-cycle registered pulse on terminal tick
remaining  output  W  ticks left before expiry
expire_cnt  output  CW  number of expiries since reset, saturates at all-ones

Behaviour:
- Reset (rstn=0 at rising clk edge, synchronous): state=IDLE, busy=0, expired=0, remaining=0, expire_cnt=0, latched period=0, latched mode=0. Reset overrides all inputs, mid-run included.
- States: IDLE, RUN, PAUSE; encoded 2 bits, all outputs registered.
- Input priority each cycle: stop > start > hold > tick_in.
- IDLE: start=1 and load_val!=0 -> latch period=load_val, mode=periodic, remaining=load_val, go RUN. start with load_val==0 ignored (stay IDLE, no pulse). tick_in/hold ignored.
- RUN: stop -> IDLE, remaining=0, no expired pulse. start (load_val!=0) -> restart: re-latch period/mode, remaining=load_val, stay RUN, pending tick discarded; start with load_val==0 treated as stop. hold=1 -> PAUSE, tick this cycle discarded. tick_in with remaining>1 -> remaining-1. tick_in with remaining==1 -> expired=1 next cycle; periodic: remaining=period, stay RUN; one-shot: remaining=0, go IDLE.
- PAUSE: remaining frozen, busy=1; hold=0 -> RUN (ticks counted from next cycle); stop/start as in RUN.
- expired: asserted exactly one cycle, same edge remaining updates; cleared next cycle unless another terminal tick (possible with period=1 and tick_in every cycle: expired stays high continuously in periodic mode).
- expire_cnt: +1 per expired pulse, saturates at 2^CW-1, cleared only by reset.
- busy = (state != IDLE), registered with state.
- Latency: start -> busy/remaining valid 1 cycle later; terminal tick -> expired 1 cycle later.
- Arithmetic: remaining unsigned W bits, never decremented below 1 in RUN; no wrap.

Decomposition:
- Shared package: state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2 (2'd3 illegal -> IDLE); default widths W, CW.
- One natural sub-module: tick_timer_cnt (remaining register with load/decrement/terminal flag). FSM and expire_cnt stay in top.

Test Plan:
- Reset: drive start=1,tick_in=1 with rstn=0 for 2 cycles -> busy=0, remaining=0, expired=0, expire_cnt=0.
- One-shot: load_val=3, periodic=0, start 1 cycle, tick_in every 4th cycle -> remaining 3,2,1,0; expired one cycle after 3rd tick; busy drops same edge; expire_cnt=1.
- Periodic back-to-back: load_val=1, periodic=1, tick_in every cycle for 10 cycles -> expired high 10 consecutive cycles, remaining=1 throughout, expire_cnt=10.
- Hold/stop priority: load_val=5 running at remaining=4, hold=1 with tick_in for 3 cycles -> remaining stays 4, state PAUSE; then stop=1 and start=1 same cycle -> IDLE, remaining=0, no expired.
- Restart + zero load: in RUN remaining=2, start with load_val=7 -> remaining=7 next cycle; then start with load_val=0 -> IDLE, no pulse; start in IDLE with load_val=0 -> no change.
- Saturation (CW=2): periodic load_val=1, 5 terminal ticks -> expire_cnt 1,2,3,3,3.

Source files
------------

// File: rtl/tick_timer_fsm_pkg.sv
// Shared types and default widths for the tick timer.
package tick_timer_fsm_pkg;
    localparam int W_DEF  = 8;
    localparam int CW_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;
endpackage

// File: rtl/tick_timer_cnt.sv
// Remaining-ticks register: clear, load and decrement, plus a terminal flag for the last tick.
module tick_timer_cnt
    import tick_timer_fsm_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic         dec_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] remaining_o,
    output logic         terminal_o
);
    logic [W-1:0] rem_q;

    always_ff @(posedge clk) begin
        if (!rstn)
            rem_q <= '0;
        else if (clr_i)
            rem_q <= '0;
        else if (load_i)
            rem_q <= load_val_i;
        else if (dec_i && rem_q > W'(1))
            rem_q <= rem_q - W'(1);
    end

    assign remaining_o = rem_q;
    assign terminal_o  = (rem_q == W'(1));
endmodule

// File: rtl/tick_timer_fsm.sv
// One-shot/periodic tick timer: counts prescaler ticks down from a loaded period, pulses on expiry.
module tick_timer_fsm
    import tick_timer_fsm_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          tick_in,
    input  logic          start,
    input  logic          stop,
    input  logic          hold,
    input  logic          periodic,
    input  logic [W-1:0]  load_val,
    output logic          busy,
    output logic          expired,
    output logic [W-1:0]  remaining,
    output logic [CW-1:0] expire_cnt
);
    state_e        state_q, state_d;
    logic          busy_q, expired_q, mode_q;
    logic [W-1:0]  period_q;
    logic [CW-1:0] expire_cnt_q;

    logic          cnt_clr, cnt_load, cnt_dec, cnt_term, start_ld, term_hit;
    logic [W-1:0]  cnt_val;

    // Priority stop > start > hold > tick; start with a zero period aborts like stop.
    always_comb begin
        state_d  = state_q;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = load_val;
        start_ld = 1'b0;
        term_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!stop && start && load_val != '0) begin
                    cnt_load = 1'b1;
                    start_ld = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN, ST_PAUSE: begin
                if (stop || (start && load_val == '0)) begin
                    cnt_clr = 1'b1;
                    state_d = ST_IDLE;
                end else if (start) begin
                    cnt_load = 1'b1;
                    start_ld = 1'b1;
                    state_d  = ST_RUN;
                end else if (hold) begin
                    state_d = ST_PAUSE;
                end else if (state_q == ST_PAUSE) begin
                    state_d = ST_RUN;
                end else if (tick_in) begin
                    if (cnt_term) begin
                        term_hit = 1'b1;
                        if (mode_q) begin
                            cnt_load = 1'b1;
                            cnt_val  = period_q;
                        end else begin
                            cnt_clr = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            default: begin
                cnt_clr = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            expired_q    <= 1'b0;
            mode_q       <= 1'b0;
            period_q     <= '0;
            expire_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= (state_d != ST_IDLE);
            expired_q <= term_hit;
            if (start_ld) begin
                period_q <= load_val;
                mode_q   <= periodic;
            end
            if (term_hit && expire_cnt_q != '1)
                expire_cnt_q <= expire_cnt_q + CW'(1);
        end
    end

    tick_timer_cnt #(.W(W)) u_cnt (
        .clk        (clk),
        .rstn       (rstn),
        .clr_i      (cnt_clr),
        .load_i     (cnt_load),
        .dec_i      (cnt_dec),
        .load_val_i (cnt_val),
        .remaining_o(remaining),
        .terminal_o (cnt_term)
    );

    assign busy       = busy_q;
    assign expired    = expired_q;
    assign expire_cnt = expire_cnt_q;
endmodule

// File: tb/tb_tick_timer_fsm.sv
// Bench for tick_timer_fsm: directed scenarios with literal expectations plus random traffic
// checked every cycle against a behavioural model; a CW=2 twin exercises counter saturation.
module tb_tick_timer_fsm;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rstn, tick_in, start, stop, hold, periodic;
    logic [W-1:0] load_val;
    logic         busy_a, expired_a, busy_b, expired_b;
    logic [W-1:0] rem_a, rem_b;
    logic [7:0]   cnt_a;
    logic [1:0]   cnt_b;

    int checks = 0;
    int passed = 0;
    bit chk_en = 1'b0;

    // Model state: activity flags, ticks left, latched period/mode, total expiries.
    bit m_busy, m_paused, m_per, m_exp;
    int m_rem, m_period, m_cnt;

    always #5 clk = ~clk;

    tick_timer_fsm #(.W(W), .CW(8)) dut_a (
        .clk(clk), .rstn(rstn), .tick_in(tick_in), .start(start), .stop(stop), .hold(hold),
        .periodic(periodic), .load_val(load_val), .busy(busy_a), .expired(expired_a),
        .remaining(rem_a), .expire_cnt(cnt_a));

    tick_timer_fsm #(.W(W), .CW(2)) dut_b (
        .clk(clk), .rstn(rstn), .tick_in(tick_in), .start(start), .stop(stop), .hold(hold),
        .periodic(periodic), .load_val(load_val), .busy(busy_b), .expired(expired_b),
        .remaining(rem_b), .expire_cnt(cnt_b));

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    always @(posedge clk) begin
        m_exp = 1'b0;
        if (!rstn) begin
            m_busy = 0; m_paused = 0; m_per = 0; m_rem = 0; m_period = 0; m_cnt = 0;
        end else if (!m_busy) begin
            if (start && !stop && load_val != 0) begin
                m_busy = 1; m_paused = 0; m_per = periodic;
                m_period = int'(load_val); m_rem = m_period;
            end
        end else if (stop || (start && load_val == 0)) begin
            m_busy = 0; m_paused = 0; m_rem = 0;
        end else if (start) begin
            m_paused = 0; m_per = periodic; m_period = int'(load_val); m_rem = m_period;
        end else if (hold) begin
            m_paused = 1;
        end else if (m_paused) begin
            m_paused = 0;
        end else if (tick_in) begin
            if (m_rem == 1) begin
                m_exp = 1; m_cnt++;
                if (m_per) m_rem = m_period;
                else begin m_rem = 0; m_busy = 0; end
            end else begin
                m_rem--;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",      int'(busy_a),    int'(m_busy));
            chk("expired",   int'(expired_a), int'(m_exp));
            chk("remaining", int'(rem_a),     m_rem);
            chk("cnt8",      int'(cnt_a),     (m_cnt > 255) ? 255 : m_cnt);
            chk("busy_b",    int'(busy_b),    int'(m_busy));
            chk("expired_b", int'(expired_b), int'(m_exp));
            chk("rem_b",     int'(rem_b),     m_rem);
            chk("cnt2",      int'(cnt_b),     (m_cnt > 3) ? 3 : m_cnt);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_in();
        tick_in = 0; start = 0; stop = 0; hold = 0; periodic = 0; load_val = '0;
    endtask

    task automatic do_reset();
        idle_in();
        rstn = 0; start = 1; tick_in = 1; load_val = 8'd5;
        repeat (2) step();
        idle_in();
        rstn = 1;
    endtask

    task automatic go(input int lv, input bit per);
        start = 1; load_val = W'(lv); periodic = per;
        step();
        start = 0; periodic = 0; load_val = '0;
    endtask

    initial begin
        idle_in();
        rstn = 0;
        chk_en = 1;
        do_reset();
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_rem", int'(rem_a), 0);
        chk("rst_exp", int'(expired_a), 0);
        chk("rst_cnt", int'(cnt_a), 0);

        // One-shot, period 3, tick every 4th cycle.
        go(3, 0);
        chk("os_busy", int'(busy_a), 1);
        chk("os_rem0", int'(rem_a), 3);
        for (int k = 1; k <= 3; k++) begin
            repeat (3) step();
            tick_in = 1; step(); tick_in = 0;
            chk("os_rem", int'(rem_a), (k == 3) ? 0 : 3 - k);
            chk("os_exp", int'(expired_a), (k == 3) ? 1 : 0);
        end
        chk("os_busy_end", int'(busy_a), 0);
        chk("os_cnt", int'(cnt_a), 1);
        step();
        chk("os_exp_clr", int'(expired_a), 0);

        // Periodic period 1, tick every cycle; CW=2 twin saturates at 3.
        do_reset();
        go(1, 1);
        tick_in = 1;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("per_exp", int'(expired_a), 1);
            chk("per_rem", int'(rem_a), 1);
            if (k <= 5) chk("sat_cnt", int'(cnt_b), (k > 3) ? 3 : k);
        end
        tick_in = 0;
        chk("per_cnt", int'(cnt_a), 10);
        step();
        chk("per_exp_clr", int'(expired_a), 0);

        // Hold discards ticks; stop beats start.
        go(5, 0);
        tick_in = 1; step();
        chk("hold_rem4", int'(rem_a), 4);
        hold = 1;
        repeat (3) step();
        chk("hold_rem", int'(rem_a), 4);
        chk("hold_busy", int'(busy_a), 1);
        hold = 0; tick_in = 0; stop = 1; start = 1; load_val = 8'd9;
        step();
        idle_in();
        chk("stop_busy", int'(busy_a), 0);
        chk("stop_rem", int'(rem_a), 0);
        chk("stop_exp", int'(expired_a), 0);

        // Restart mid-run, then zero-period start aborts; zero start in idle is ignored.
        go(4, 0);
        tick_in = 1; repeat (2) step(); tick_in = 0;
        chk("rs_rem2", int'(rem_a), 2);
        go(7, 0);
        chk("rs_rem7", int'(rem_a), 7);
        go(0, 0);
        chk("z_busy", int'(busy_a), 0);
        chk("z_rem", int'(rem_a), 0);
        chk("z_exp", int'(expired_a), 0);
        go(0, 1);
        chk("z_idle_busy", int'(busy_a), 0);
        chk("z_idle_rem", int'(rem_a), 0);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            rstn     = ($urandom_range(0, 299) != 0);
            tick_in  = ($urandom_range(0, 1) == 1);
            start    = ($urandom_range(0, 9) == 0);
            stop     = ($urandom_range(0, 24) == 0);
            hold     = ($urandom_range(0, 7) == 0);
            periodic = ($urandom_range(0, 1) == 1);
            load_val = ($urandom_range(0, 15) == 0) ? W'($urandom_range(0, 255))
                                                     : W'($urandom_range(0, 5));
            step();
        end
        idle_in();
        step();
        chk_en = 0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
